// File: rtl/sr_latch_bank_ctrl_pkg.sv
// Shared opcode and FSM state encodings for the SR latch bank controller.
package sr_latch_bank_ctrl_pkg;

  localparam logic [1:0] OP_READ = 2'b00;
  localparam logic [1:0] OP_SET  = 2'b01;
  localparam logic [1:0] OP_CLR  = 2'b10;
  localparam logic [1:0] OP_TGL  = 2'b11;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ARB    = 3'd1;
  localparam logic [2:0] ST_PULSE  = 3'd2;
  localparam logic [2:0] ST_SETTLE = 3'd3;
  localparam logic [2:0] ST_CHECK  = 3'd4;

  function automatic logic is_write(input logic [1:0] op);
    return op != OP_READ;
  endfunction

endpackage

// File: rtl/sr_latch_bank_ctrl_if.sv
// Requester-side flag interface: packed per-requester request, opcode, index and responses.
interface sr_latch_bank_ctrl_if #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 3
);
  logic [NUM_REQ-1:0]       req;
  logic [2*NUM_REQ-1:0]     op;
  logic [IDX_W*NUM_REQ-1:0] idx;
  logic [NUM_REQ-1:0]       gnt;
  logic [NUM_REQ-1:0]       ack;
  logic                     rdata;
  logic                     err;
  logic                     busy;

  modport master (output req, op, idx, input gnt, ack, rdata, err, busy);
  modport slave  (input req, op, idx, output gnt, ack, rdata, err, busy);
endinterface

// File: rtl/sr_latch_bank_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first active request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win,
  output logic [PTR_W-1:0]   win_idx,
  output logic               found
);

  always_comb begin
    int c;
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    c       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      c = int'(ptr) + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (j == c && !found && req[j]) begin
          found   = 1'b1;
          win[j]  = 1'b1;
          win_idx = PTR_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/sr_latch_bank_ctrl.sv
// Round-robin controller sequencing S/R/En pulses into a shared bank of enabled SR latches,
// with a settle cycle and read-back check after every write.
module sr_latch_bank_ctrl
  import sr_latch_bank_ctrl_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int NUM_LATCH = 8,
  parameter int IDX_W     = 3,
  parameter int PULSE_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  sr_latch_bank_ctrl_if.slave  bus,
  output logic [NUM_LATCH-1:0] latch_s,
  output logic [NUM_LATCH-1:0] latch_r,
  output logic [NUM_LATCH-1:0] latch_en,
  input  logic [NUM_LATCH-1:0] latch_q
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;

  logic [2:0]           state;
  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     gidx;
  logic [NUM_REQ-1:0]   gnt_r;
  logic [1:0]           op_r;
  logic [IDX_W-1:0]     idx_r;
  logic                 exp_q;
  logic [CNT_W-1:0]     pcnt;

  logic [NUM_REQ-1:0]   win;
  logic [PTR_W-1:0]     win_idx;
  logic                 win_found;
  logic [1:0]           win_op;
  logic [IDX_W-1:0]     win_lidx;
  logic [NUM_LATCH-1:0] idx_hot;
  logic                 in_range;
  logic                 q_sel;
  logic                 in_check;

  function automatic logic [NUM_LATCH-1:0] decode_idx(input logic [IDX_W-1:0] ix);
    logic [NUM_LATCH-1:0] hot;
    hot = '0;
    for (int i = 0; i < NUM_LATCH; i++) begin
      if (int'(ix) == i) hot[i] = 1'b1;
    end
    return hot;
  endfunction

  function automatic logic expected_q(input logic [1:0] op, input logic q);
    case (op)
      OP_SET:  return 1'b1;
      OP_CLR:  return 1'b0;
      default: return ~q;
    endcase
  endfunction

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
    .req     (bus.req),
    .ptr     (rr_ptr),
    .win     (win),
    .win_idx (win_idx),
    .found   (win_found)
  );

  // Only the winning requester's opcode and index fields are decoded.
  always_comb begin
    win_op   = '0;
    win_lidx = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (win[r]) begin
        win_op   = bus.op[2*r +: 2];
        win_lidx = bus.idx[IDX_W*r +: IDX_W];
      end
    end
  end

  assign idx_hot  = decode_idx(idx_r);
  assign in_range = |idx_hot;
  assign q_sel    = |(idx_hot & latch_q);
  assign in_check = (state == ST_CHECK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      rr_ptr <= '0;
    end else begin
      case (state)
        ST_IDLE:   if (win_found) state <= ST_ARB;
        ST_ARB:    state <= (op_r == OP_READ || !in_range) ? ST_CHECK : ST_PULSE;
        ST_PULSE:  if (int'(pcnt) == PULSE_CYC - 1) state <= ST_SETTLE;
        ST_SETTLE: state <= ST_CHECK;
        ST_CHECK: begin
          state  <= ST_IDLE;
          rr_ptr <= (int'(gidx) == NUM_REQ - 1) ? '0 : gidx + 1'b1;
        end
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Request fields are captured once in IDLE; later changes on the bus are ignored.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && win_found) begin
      gnt_r <= win;
      gidx  <= win_idx;
      op_r  <= win_op;
      idx_r <= win_lidx;
    end
    if (state == ST_ARB) begin
      pcnt  <= '0;
      exp_q <= expected_q(op_r, q_sel);
    end else if (state == ST_PULSE) begin
      pcnt  <= pcnt + 1'b1;
    end
  end

  assign bus.busy  = (state != ST_IDLE);
  assign bus.gnt   = bus.busy ? gnt_r : '0;
  assign bus.ack   = in_check ? gnt_r : '0;
  assign bus.rdata = in_check & q_sel;
  assign bus.err   = in_check & (!in_range | (is_write(op_r) & (q_sel != exp_q)));

  // S and R are complementary copies of one enable, so they can never both be high.
  assign latch_en = (state == ST_PULSE) ? idx_hot : '0;
  assign latch_s  = exp_q ? latch_en : '0;
  assign latch_r  = exp_q ? '0 : latch_en;

endmodule

// File: tb/tb_sr_latch_bank_ctrl.sv
// Bench for sr_latch_bank_ctrl: behavioural latch bank on the pins, transaction-level model of
// arbitration and latch contents, directed scenarios plus randomized single and contended ops.
`timescale 1ns/1ps
module tb_sr_latch_bank_ctrl;
  localparam int NUM_REQ   = 4;
  localparam int NUM_LATCH = 8;
  localparam int IDX_W     = 4;
  localparam int PULSE_CYC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NUM_LATCH-1:0] latch_s, latch_r, latch_en, latch_q;
  logic [NUM_LATCH-1:0] stuck_mask = '0;
  logic [NUM_LATCH-1:0] stuck_val  = '0;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [NUM_LATCH-1:0] m_mem = '0;
  int m_ptr = 0;

  sr_latch_bank_ctrl_if #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) bus ();

  sr_latch_bank_ctrl #(.NUM_REQ(NUM_REQ), .NUM_LATCH(NUM_LATCH), .IDX_W(IDX_W), .PULSE_CYC(PULSE_CYC)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .latch_s(latch_s), .latch_r(latch_r), .latch_en(latch_en), .latch_q(latch_q)
  );

  always #5 clk = ~clk;

  for (genvar i = 0; i < NUM_LATCH; i++) begin : g_latch
    logic cell_q = 1'b0;
    always @(posedge clk) begin
      if (latch_en[i]) begin
        if (latch_s[i] && !latch_r[i]) cell_q <= 1'b1;
        else if (latch_r[i] && !latch_s[i]) cell_q <= 1'b0;
        else if (latch_s[i] && latch_r[i]) cell_q <= 1'bx;
      end
    end
    assign latch_q[i] = stuck_mask[i] ? stuck_val[i] : cell_q;
  end

  always @(negedge clk) begin
    n_cmp++;
    if ((latch_s & latch_r) !== '0 || !$onehot0(latch_en) || ((latch_s | latch_r) & ~latch_en) !== '0) begin
      n_fail++;
      $display("FAIL pin_invariant t=%0t s=%b r=%b en=%b required s&r=0, en one-hot-or-zero, s|r within en", $time, latch_s, latch_r, latch_en);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int model_winner(input logic [NUM_REQ-1:0] mask);
    int c;
    for (int k = 0; k < NUM_REQ; k++) begin
      c = (m_ptr + k) % NUM_REQ;
      if (mask[c]) begin
        m_ptr = (c + 1) % NUM_REQ;
        return c;
      end
    end
    return -1;
  endfunction

  function automatic void model_op(input int opv, input int ix, output logic rd, output logic er);
    if (ix >= NUM_LATCH) begin
      rd = 1'b0; er = 1'b1;
      return;
    end
    case (opv)
      1: m_mem[ix] = 1'b1;
      2: m_mem[ix] = 1'b0;
      3: m_mem[ix] = ~m_mem[ix];
      default: ;
    endcase
    rd = m_mem[ix]; er = 1'b0;
  endfunction

  task automatic set_req(input int r, input int opv, input int ix);
    bus.req[r] = 1'b1;
    bus.op[2*r +: 2] = 2'(opv);
    bus.idx[IDX_W*r +: IDX_W] = IDX_W'(ix);
  endtask

  task automatic run_op(input int r, input int opv, input int ix, input bit disturb,
                        output int g_at, output int a_at, output int en_cnt,
                        output logic [NUM_REQ-1:0] g_v, output logic [NUM_REQ-1:0] a_v,
                        output logic rd, output logic er,
                        output logic [NUM_LATCH-1:0] s_acc, output logic [NUM_LATCH-1:0] r_acc,
                        output logic [NUM_LATCH-1:0] en_acc);
    g_at = -1; a_at = -1; en_cnt = 0; g_v = '0; a_v = '0; rd = 1'b0; er = 1'b0;
    s_acc = '0; r_acc = '0; en_acc = '0;
    @(posedge clk); #1;
    set_req(r, opv, ix);
    for (int k = 0; k < 30 && a_at < 0; k++) begin
      @(negedge clk);
      s_acc |= latch_s; r_acc |= latch_r; en_acc |= latch_en;
      if (latch_en !== '0) en_cnt++;
      if (g_at < 0 && bus.gnt !== '0) begin
        g_at = k; g_v = bus.gnt;
        if (disturb) begin
          bus.req[r] = 1'b0;
          bus.op = 8'($urandom);
          bus.idx = 16'($urandom);
        end
      end
      if (bus.ack !== '0) begin
        a_at = k; a_v = bus.ack; rd = bus.rdata; er = bus.err;
      end
    end
    @(posedge clk); #1;
    bus.req = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = '0; bus.op = '0; bus.idx = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.gnt, bus.ack, bus.rdata, bus.err, bus.busy} !== '0 || {latch_s, latch_r, latch_en} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs gnt=%b ack=%b rdata=%b err=%b busy=%b s=%h r=%h en=%h required all 0", bus.gnt, bus.ack, bus.rdata, bus.err, bus.busy, latch_s, latch_r, latch_en);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.gnt !== '0) begin
      n_fail++;
      $display("FAIL reset_idle busy=%b gnt=%b required 0/0000", bus.busy, bus.gnt);
    end
    m_ptr = 0;
  endtask

  task automatic test_set();
    int g_at, a_at, en_cnt, w;
    logic [NUM_REQ-1:0] g_v, a_v;
    logic rd, er, erd, eer;
    logic [NUM_LATCH-1:0] s_acc, r_acc, en_acc;
    w = model_winner(4'b0001);
    model_op(1, 3, erd, eer);
    run_op(0, 1, 3, 1'b0, g_at, a_at, en_cnt, g_v, a_v, rd, er, s_acc, r_acc, en_acc);
    n_cmp++;
    if (g_at !== 1 || g_v !== 4'(1 << w)) begin
      n_fail++; $display("FAIL set_gnt at=%0d gnt=%b required at=1 gnt=%b", g_at, g_v, 4'(1 << w));
    end
    n_cmp++;
    if (a_at !== PULSE_CYC + 3 || a_v !== 4'b0001) begin
      n_fail++; $display("FAIL set_ack at=%0d ack=%b required at=%0d ack=0001", a_at, a_v, PULSE_CYC + 3);
    end
    n_cmp++;
    if (en_acc !== 8'h08 || s_acc !== 8'h08 || r_acc !== 8'h00 || en_cnt !== PULSE_CYC) begin
      n_fail++; $display("FAIL set_pins en=%h s=%h r=%h cycles=%0d required 08/08/00 cycles=%0d", en_acc, s_acc, r_acc, en_cnt, PULSE_CYC);
    end
    n_cmp++;
    if (rd !== erd || er !== eer || latch_q[3] !== 1'b1) begin
      n_fail++; $display("FAIL set_result rdata=%b err=%b q3=%b required %b/%b/1", rd, er, latch_q[3], erd, eer);
    end
  endtask

  task automatic test_toggle_read();
    int g_at, a_at, en_cnt, w;
    logic [NUM_REQ-1:0] g_v, a_v;
    logic rd, er, erd, eer;
    logic [NUM_LATCH-1:0] s_acc, r_acc, en_acc;
    w = model_winner(4'b0010);
    model_op(3, 3, erd, eer);
    run_op(1, 3, 3, 1'b0, g_at, a_at, en_cnt, g_v, a_v, rd, er, s_acc, r_acc, en_acc);
    n_cmp++;
    if (s_acc !== 8'h00 || r_acc !== 8'h08 || en_cnt !== PULSE_CYC) begin
      n_fail++; $display("FAIL tgl_pins s=%h r=%h cycles=%0d required 00/08 cycles=%0d", s_acc, r_acc, en_cnt, PULSE_CYC);
    end
    n_cmp++;
    if (a_v !== 4'(1 << w) || a_at !== PULSE_CYC + 3 || rd !== erd || er !== eer) begin
      n_fail++; $display("FAIL tgl_ack ack=%b at=%0d rdata=%b err=%b required %b/%0d/%b/%b", a_v, a_at, rd, er, 4'(1 << w), PULSE_CYC + 3, erd, eer);
    end
    w = model_winner(4'b0010);
    model_op(0, 3, erd, eer);
    run_op(1, 0, 3, 1'b0, g_at, a_at, en_cnt, g_v, a_v, rd, er, s_acc, r_acc, en_acc);
    n_cmp++;
    if (a_at !== 2 || a_v !== 4'(1 << w) || rd !== erd || er !== eer || en_acc !== '0) begin
      n_fail++; $display("FAIL read_ack at=%0d ack=%b rdata=%b err=%b en=%h required 2/%b/%b/%b/00", a_at, a_v, rd, er, en_acc, 4'(1 << w), erd, eer);
    end
  endtask

  task automatic test_out_of_range();
    int g_at, a_at, en_cnt, w;
    logic [NUM_REQ-1:0] g_v, a_v;
    logic rd, er, erd, eer;
    logic [NUM_LATCH-1:0] s_acc, r_acc, en_acc;
    w = model_winner(4'b0100);
    model_op(1, 9, erd, eer);
    run_op(2, 1, 9, 1'b0, g_at, a_at, en_cnt, g_v, a_v, rd, er, s_acc, r_acc, en_acc);
    n_cmp++;
    if ({s_acc, r_acc, en_acc} !== '0) begin
      n_fail++; $display("FAIL oor_pins s=%h r=%h en=%h required 0", s_acc, r_acc, en_acc);
    end
    n_cmp++;
    if (a_at !== 2 || a_v !== 4'(1 << w) || rd !== erd || er !== eer) begin
      n_fail++; $display("FAIL oor_ack at=%0d ack=%b rdata=%b err=%b required 2/%b/%b/%b", a_at, a_v, rd, er, 4'(1 << w), erd, eer);
    end
  endtask

  task automatic test_back_to_back();
    int order[$];
    int gt[$];
    int at[$];
    logic [NUM_REQ-1:0] prev;
    int w;
    logic erd, eer;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_ptr = 0;
    for (int k = 0; k < NUM_REQ; k++) set_req(k, 1, (k * 3 + 1) % NUM_LATCH);
    prev = '0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (bus.gnt !== '0 && prev === '0) begin
        order.push_back($clog2(bus.gnt));
        gt.push_back(k);
      end
      prev = bus.gnt;
      if (bus.ack !== '0) begin
        at.push_back(k);
        n_cmp++;
        if (order.size() == 0 || bus.ack !== 4'(1 << order[order.size()-1]) || bus.rdata !== 1'b1 || bus.err !== 1'b0) begin
          n_fail++; $display("FAIL b2b_ack ack=%b rdata=%b err=%b required one-hot of last grant, 1, 0", bus.ack, bus.rdata, bus.err);
        end
      end
      if (order.size() >= 5 && at.size() >= order.size()) break;
      if (order.size() == 5 && bus.req !== '0) begin
        @(posedge clk); #1;
        bus.req = '0;
      end
    end
    @(posedge clk); #1;
    bus.req = '0;
    n_cmp++;
    if (order.size() !== 5 || at.size() !== 5) begin
      n_fail++; $display("FAIL b2b_count grants=%0d acks=%0d required 5/5", order.size(), at.size());
    end
    for (int j = 0; j < order.size(); j++) begin
      w = model_winner(4'hF);
      model_op(1, (w * 3 + 1) % NUM_LATCH, erd, eer);
      n_cmp++;
      if (order[j] !== w) begin
        n_fail++; $display("FAIL b2b_order grant#%0d got=%0d required=%0d", j, order[j], w);
      end
      if (j >= 1 && j - 1 < at.size()) begin
        n_cmp++;
        if (gt[j] !== at[j-1] + 2) begin
          n_fail++; $display("FAIL b2b_gap grant#%0d at=%0d required=%0d", j, gt[j], at[j-1] + 2);
        end
      end
    end
  endtask

  task automatic test_reset_abort();
    int g_at, a_at, en_cnt, w;
    logic [NUM_REQ-1:0] g_v, a_v;
    logic rd, er, erd, eer;
    logic [NUM_LATCH-1:0] s_acc, r_acc, en_acc;
    bit seen, bad, got_g, got_a;
    w = model_winner(4'b0010);
    model_op(0, 0, erd, eer);
    run_op(1, 0, 0, 1'b0, g_at, a_at, en_cnt, g_v, a_v, rd, er, s_acc, r_acc, en_acc);
    n_cmp++;
    if (a_v !== 4'(1 << w) || rd !== erd) begin
      n_fail++; $display("FAIL abort_pre ack=%b rdata=%b required %b/%b", a_v, rd, 4'(1 << w), erd);
    end
    @(posedge clk); #1;
    set_req(2, 1, 5);
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clk);
      if (latch_en[5] === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_fail++; $display("FAIL abort_pulse en5 seen=%b required 1", seen);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({bus.gnt, bus.ack, bus.rdata, bus.err, bus.busy} !== '0 || {latch_s, latch_r, latch_en} !== '0) begin
      n_fail++; $display("FAIL abort_outputs gnt=%b ack=%b busy=%b s=%h r=%h en=%h required all 0", bus.gnt, bus.ack, bus.busy, latch_s, latch_r, latch_en);
    end
    rst = 1'b0;
    bus.req = '0;
    m_ptr = 0;
    m_mem[5] = 1'b1;
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.ack !== '0 || bus.busy !== 1'b0) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_fail++; $display("FAIL abort_no_ack ack/busy activity=%b required 0", bad);
    end
    @(posedge clk); #1;
    set_req(1, 0, 5);
    set_req(3, 0, 5);
    w = model_winner(4'b1010);
    model_op(0, 5, erd, eer);
    got_g = 1'b0; got_a = 1'b0; g_v = '0; a_v = '0; rd = 1'b0; er = 1'b0;
    for (int k = 0; k < 15 && !got_a; k++) begin
      @(negedge clk);
      if (!got_g && bus.gnt !== '0) begin got_g = 1'b1; g_v = bus.gnt; end
      if (bus.ack !== '0) begin got_a = 1'b1; a_v = bus.ack; rd = bus.rdata; er = bus.err; end
    end
    @(posedge clk); #1;
    bus.req = '0;
    n_cmp++;
    if (g_v !== 4'(1 << w) || a_v !== 4'(1 << w)) begin
      n_fail++; $display("FAIL abort_ptr gnt=%b ack=%b required %b", g_v, a_v, 4'(1 << w));
    end
    n_cmp++;
    if (rd !== erd || er !== eer) begin
      n_fail++; $display("FAIL abort_readback rdata=%b err=%b required %b/%b", rd, er, erd, eer);
    end
  endtask

  task automatic test_stuck();
    int g_at, a_at, en_cnt, w;
    logic [NUM_REQ-1:0] g_v, a_v;
    logic rd, er, erd, eer;
    logic [NUM_LATCH-1:0] s_acc, r_acc, en_acc;
    stuck_mask = 8'h40;
    stuck_val  = 8'h00;
    w = model_winner(4'b1000);
    model_op(1, 6, erd, eer);
    run_op(3, 1, 6, 1'b0, g_at, a_at, en_cnt, g_v, a_v, rd, er, s_acc, r_acc, en_acc);
    stuck_mask = '0;
    n_cmp++;
    if (a_at !== PULSE_CYC + 3 || a_v !== 4'(1 << w) || er !== 1'b1 || rd !== 1'b0 || s_acc !== 8'h40) begin
      n_fail++; $display("FAIL stuck_err at=%0d ack=%b err=%b rdata=%b s=%h required %0d/%b/1/0/40", a_at, a_v, er, rd, s_acc, PULSE_CYC + 3, 4'(1 << w));
    end
  endtask

  task automatic test_random();
    int g_at, a_at, en_cnt, w, r, opv, ix, exp_lat, exp_cnt;
    logic [NUM_REQ-1:0] g_v, a_v;
    logic rd, er, erd, eer;
    logic [NUM_LATCH-1:0] s_acc, r_acc, en_acc, hot, exp_s, exp_r;
    bit disturb, wr;
    for (int it = 0; it < 24; it++) begin
      r = $urandom_range(0, NUM_REQ - 1);
      opv = $urandom_range(0, 3);
      ix = $urandom_range(0, 9);
      disturb = 1'($urandom_range(0, 1));
      w = model_winner(4'(1 << r));
      model_op(opv, ix, erd, eer);
      hot = '0;
      if (ix < NUM_LATCH) hot[ix] = 1'b1;
      wr = (opv != 0) && (ix < NUM_LATCH);
      exp_lat = wr ? PULSE_CYC + 3 : 2;
      exp_cnt = wr ? PULSE_CYC : 0;
      exp_s = (wr && erd) ? hot : '0;
      exp_r = (wr && !erd) ? hot : '0;
      run_op(r, opv, ix, disturb, g_at, a_at, en_cnt, g_v, a_v, rd, er, s_acc, r_acc, en_acc);
      n_cmp++;
      if (g_at !== 1 || g_v !== 4'(1 << w) || a_at !== exp_lat || a_v !== 4'(1 << w)) begin
        n_fail++; $display("FAIL rand_timing it=%0d gnt@%0d=%b ack@%0d=%b required gnt@1=%b ack@%0d", it, g_at, g_v, a_at, a_v, 4'(1 << w), exp_lat);
      end
      n_cmp++;
      if (rd !== erd || er !== eer) begin
        n_fail++; $display("FAIL rand_result it=%0d op=%0d idx=%0d rdata=%b err=%b required %b/%b", it, opv, ix, rd, er, erd, eer);
      end
      n_cmp++;
      if (s_acc !== exp_s || r_acc !== exp_r || en_acc !== (wr ? hot : 8'h00) || en_cnt !== exp_cnt) begin
        n_fail++; $display("FAIL rand_pins it=%0d s=%h r=%h en=%h cyc=%0d required %h/%h/%h cyc=%0d", it, s_acc, r_acc, en_acc, en_cnt, exp_s, exp_r, wr ? hot : 8'h00, exp_cnt);
      end
    end
  endtask

  initial begin
    bus.req = '0; bus.op = '0; bus.idx = '0;
    test_reset();
    test_set();
    test_toggle_read();
    test_out_of_range();
    test_back_to_back();
    test_reset_abort();
    test_stuck();
    test_random();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
